// File: rtl/vga_vram_arbiter_if.sv
// Bus between the VRAM arbiter and its neighbours: sync-generator counters,
// game-logic write requesters, the tile RAM port and the display-side outputs.
interface vga_vram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic [9:0]        i_Col_Count;
    logic [9:0]        i_Row_Count;
    logic [1:0]        i_Wr_Req;
    logic [ADDR_W-1:0] i_Wr_Addr_0;
    logic [ADDR_W-1:0] i_Wr_Addr_1;
    logic [DATA_W-1:0] i_Wr_Data_0;
    logic [DATA_W-1:0] i_Wr_Data_1;
    logic [1:0]        o_Wr_Ack;
    logic [ADDR_W-1:0] o_Ram_Addr;
    logic [DATA_W-1:0] o_Ram_WData;
    logic              o_Ram_We;
    logic [DATA_W-1:0] i_Ram_RData;
    logic [DATA_W-1:0] o_Tile_Data;
    logic              o_Tile_Valid;
    logic              o_Frame_Start;

    // Arbiter side.
    modport slave (
        input  i_Col_Count, i_Row_Count, i_Wr_Req,
        input  i_Wr_Addr_0, i_Wr_Addr_1, i_Wr_Data_0, i_Wr_Data_1,
        input  i_Ram_RData,
        output o_Wr_Ack, o_Ram_Addr, o_Ram_WData, o_Ram_We,
        output o_Tile_Data, o_Tile_Valid, o_Frame_Start
    );

    // Surroundings: sync generator, writers and the RAM.
    modport master (
        output i_Col_Count, i_Row_Count, i_Wr_Req,
        output i_Wr_Addr_0, i_Wr_Addr_1, i_Wr_Data_0, i_Wr_Data_1,
        output i_Ram_RData,
        input  o_Wr_Ack, o_Ram_Addr, o_Ram_WData, o_Ram_We,
        input  o_Tile_Data, o_Tile_Valid, o_Frame_Start
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port tile RAM between the display tile fetch (always wins its
// slot) and two round-robin game-logic writers; also emits a frame-start pulse.
module vga_vram_arbiter #(
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int TILE_SHIFT    = 4,
    parameter int TILES_PER_ROW = 40,
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 8,
    parameter int WR_IN_ACTIVE  = 1
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    vga_vram_arbiter_if.slave   bus
);
    localparam logic [9:0] COL_LIMIT = 10'(ACTIVE_COLS);
    localparam logic [9:0] ROW_LIMIT = 10'(ACTIVE_ROWS);

    logic              active;
    logic              fetch_slot;
    logic              window_open;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] fetch_addr;
    logic              rr_last;   // 1 = writer 1 was granted most recently
    logic              fetch_d1;
    logic              fetch_d2;

    assign active      = (bus.i_Col_Count < COL_LIMIT) && (bus.i_Row_Count < ROW_LIMIT);
    assign fetch_slot  = active && (bus.i_Col_Count[TILE_SHIFT-1:0] == '0);
    assign window_open = (WR_IN_ACTIVE != 0) || !active;
    assign fetch_addr  = ADDR_W'((32'(bus.i_Row_Count) >> TILE_SHIFT) * 32'(TILES_PER_ROW)
                                + (32'(bus.i_Col_Count) >> TILE_SHIFT));

    // A writer still seeing its ack is not eligible, so a held request is never granted twice.
    assign eligible = bus.i_Wr_Req & ~bus.o_Wr_Ack;

    always_comb begin
        // NOTE: default assignment first so every path drives grant and no latch is inferred.
        grant = 2'b00;
        if (!fetch_slot && window_open) begin
            case (eligible)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bus.o_Wr_Ack      <= 2'b00;
            bus.o_Ram_Addr    <= '0;
            bus.o_Ram_WData   <= '0;
            bus.o_Ram_We      <= 1'b0;
            bus.o_Tile_Data   <= '0;
            bus.o_Tile_Valid  <= 1'b0;
            bus.o_Frame_Start <= 1'b0;
            rr_last           <= 1'b1;
            fetch_d1          <= 1'b0;
            fetch_d2          <= 1'b0;
        end else begin
            bus.o_Wr_Ack      <= grant;
            bus.o_Ram_We      <= |grant;
            bus.o_Frame_Start <= (bus.i_Col_Count == '0) && (bus.i_Row_Count == '0);
            fetch_d1          <= fetch_slot;
            fetch_d2          <= fetch_d1;
            bus.o_Tile_Valid  <= fetch_d2;
            // RAM data for a fetch issued at N is on i_Ram_RData during N+2.
            if (fetch_d2) begin
                bus.o_Tile_Data <= bus.i_Ram_RData;
            end
            if (fetch_slot) begin
                bus.o_Ram_Addr <= fetch_addr;
            end else if (grant[0]) begin
                bus.o_Ram_Addr  <= bus.i_Wr_Addr_0;
                bus.o_Ram_WData <= bus.i_Wr_Data_0;
                rr_last         <= 1'b0;
            end else if (grant[1]) begin
                bus.o_Ram_Addr  <= bus.i_Wr_Addr_1;
                bus.o_Ram_WData <= bus.i_Wr_Data_1;
                rr_last         <= 1'b1;
            end
        end
    end
endmodule
